// File: rtl/text_overlay_ctrl_pkg.sv
// Shared codes for the text overlay sequencer.
// Optional feature macro: TEXT_PROMPT_BLINK_EN (undefined by default -> steady prompt).
package text_overlay_ctrl_pkg;

    localparam logic [1:0] GS_MENU = 2'b00;
    localparam logic [1:0] GS_PLAY = 2'b01;
    localparam logic [1:0] GS_OVER = 2'b10;

    typedef enum logic [2:0] {
        S_BLANK       = 3'd0,
        S_MENU_HOLD   = 3'd1,
        S_MENU_PROMPT = 3'd2,
        S_PLAY        = 3'd3,
        S_OVER_HOLD   = 3'd4,
        S_OVER_PROMPT = 3'd5
    } ovl_state_e;

    function automatic logic is_menu(input ovl_state_e s);
        return (s == S_MENU_HOLD) || (s == S_MENU_PROMPT);
    endfunction

    function automatic logic is_over(input ovl_state_e s);
        return (s == S_OVER_HOLD) || (s == S_OVER_PROMPT);
    endfunction

    function automatic logic is_prompt(input ovl_state_e s);
        return (s == S_MENU_PROMPT) || (s == S_OVER_PROMPT);
    endfunction

endpackage

// File: rtl/text_overlay_ctrl_frame_tick_gen.sv
// vsync rising-edge detector; frame_tick is a registered one-cycle pulse
// in the cycle after the vsync rise.
module frame_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic frame_tick
);

    logic vsync_d_q, vsync_d_d;
    logic tick_q, tick_d;

    always_comb begin
        vsync_d_d = vsync;
        tick_d    = vsync & ~vsync_d_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            vsync_d_q <= vsync_d_d;
            tick_q    <= tick_d;
        end
    end

    assign frame_tick = tick_q;

endmodule

// File: rtl/text_overlay_ctrl.sv
// Drives string-overlay enables from game state, hold-off and blink timing;
// enables only change at frame start. Blink gated by TEXT_PROMPT_BLINK_EN.
module text_overlay_ctrl
    import text_overlay_ctrl_pkg::*;
#(
    parameter int HOLDOFF_FRAMES = 30,
    parameter int BLINK_FRAMES   = 20,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic [1:0] game_state,
    input  logic       key_space,
    output logic       title_en,
    output logic       prompt_en,
    output logic       over_en,
    output logic       score_en,
    output logic       start_req
);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic frame_tick;

    frame_tick_gen u_tick (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vsync),
        .frame_tick (frame_tick)
    );

    ovl_state_e       state_q, state_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             blink_ph_q, blink_ph_d;
    logic             title_en_q, title_en_d;
    logic             prompt_en_q, prompt_en_d;
    logic             over_en_q, over_en_d;
    logic             score_en_q, score_en_d;
    logic             start_req_q, start_req_d;
    logic             req_latched_q, req_latched_d;
    logic             fire;

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        blink_ph_d  = blink_ph_q;
        title_en_d  = title_en_q;
        prompt_en_d = prompt_en_q;
        over_en_d   = over_en_q;
        score_en_d  = score_en_q;

        if (frame_tick) begin
            case (game_state)
                GS_MENU: state_d = is_menu(state_q) ? state_q : S_MENU_HOLD;
                GS_OVER: state_d = is_over(state_q) ? state_q : S_OVER_HOLD;
                default: state_d = S_PLAY;
            endcase

            if (state_d == state_q && frame_cnt_q == HOLD_LAST) begin
                if (state_q == S_MENU_HOLD) state_d = S_MENU_PROMPT;
                if (state_q == S_OVER_HOLD) state_d = S_OVER_PROMPT;
            end

            if (state_d != state_q) begin
                frame_cnt_d = '0;
                if (is_prompt(state_d)) blink_ph_d = 1'b1;
            end else if (state_q == S_MENU_HOLD || state_q == S_OVER_HOLD) begin
                frame_cnt_d = (frame_cnt_q == HOLD_LAST) ? frame_cnt_q
                                                         : frame_cnt_q + CNT_W'(1);
            end else if (is_prompt(state_q)) begin
                // Counter keeps the blink cadence in both builds; only the phase toggle is optional.
                if (frame_cnt_q == BLINK_LAST) begin
                    frame_cnt_d = '0;
`ifdef TEXT_PROMPT_BLINK_EN
                    blink_ph_d  = ~blink_ph_q;
`endif
                end else begin
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                end
            end else begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end

            title_en_d  = is_menu(state_d);
            over_en_d   = is_over(state_d);
            score_en_d  = (state_d == S_PLAY) || is_over(state_d);
            prompt_en_d = is_prompt(state_d) & blink_ph_d;
        end
    end

    // One request per prompt visit; the latch drops once the state leaves PROMPT.
    always_comb begin
        fire          = key_space & is_prompt(state_q) & ~req_latched_q;
        start_req_d   = fire;
        req_latched_d = is_prompt(state_q) & (req_latched_q | fire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_BLANK;
            frame_cnt_q   <= '0;
            blink_ph_q    <= 1'b1;
            title_en_q    <= 1'b0;
            prompt_en_q   <= 1'b0;
            over_en_q     <= 1'b0;
            score_en_q    <= 1'b0;
            start_req_q   <= 1'b0;
            req_latched_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_ph_q    <= blink_ph_d;
            title_en_q    <= title_en_d;
            prompt_en_q   <= prompt_en_d;
            over_en_q     <= over_en_d;
            score_en_q    <= score_en_d;
            start_req_q   <= start_req_d;
            req_latched_q <= req_latched_d;
        end
    end

    assign title_en  = title_en_q;
    assign prompt_en = prompt_en_q;
    assign over_en   = over_en_q;
    assign score_en  = score_en_q;
    assign start_req = start_req_q;

endmodule

// File: tb/tb_text_overlay_ctrl.sv
// Bench for text_overlay_ctrl: frame-level reference model (mode + frames since entry),
// directed scenarios followed by randomized game-state changes and key presses.
module tb_text_overlay_ctrl;

    localparam int HOLD = 2;
    localparam int BLK  = 3;
`ifdef TEXT_PROMPT_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    localparam int M_BLANK = 0;
    localparam int M_MENU  = 1;
    localparam int M_PLAY  = 2;
    localparam int M_OVER  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       vsync;
    logic [1:0] game_state;
    logic       key_space;
    logic       title_en, prompt_en, over_en, score_en, start_req;

    int n_tests = 0;
    int n_fail  = 0;

    int m_mode;
    int m_age;
    bit m_latched;

    text_overlay_ctrl #(
        .HOLDOFF_FRAMES (HOLD),
        .BLINK_FRAMES   (BLK),
        .CNT_W          (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vsync),
        .game_state (game_state),
        .key_space  (key_space),
        .title_en   (title_en),
        .prompt_en  (prompt_en),
        .over_en    (over_en),
        .score_en   (score_en),
        .start_req  (start_req)
    );

    always #5 clk = ~clk;

    function automatic bit m_prompt_act();
        return (m_mode == M_MENU || m_mode == M_OVER) && (m_age >= HOLD);
    endfunction

    // {title, prompt, over, score}
    function automatic logic [3:0] m_en();
        logic vis;
        vis = !BLINK_ON || (((m_age - HOLD) / BLK) % 2 == 0);
        return {m_mode == M_MENU, m_prompt_act() && vis, m_mode == M_OVER,
                (m_mode == M_PLAY) || (m_mode == M_OVER)};
    endfunction

    task automatic m_tick(input logic [1:0] gs);
        int nm;
        nm = gs[0] ? M_PLAY : ((gs == 2'b10) ? M_OVER : M_MENU);
        if (nm != m_mode) begin
            m_mode = nm;
            m_age  = 0;
        end else begin
            m_age++;
        end
        if (!m_prompt_act()) m_latched = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1; vsync = 1'b0; key_space = 1'b0;
        m_mode = M_BLANK; m_age = 0; m_latched = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            chk("reset_en", {title_en, prompt_en, over_en, score_en}, 4'b0000);
            chk("reset_start", {3'b000, start_req}, 4'b0000);
        end
        rst = 1'b0;
    endtask

    // One 100-clock frame: vsync high for the first 10 clocks; optional
    // game_state change at cycle gs_at and key pulses at k1/k2 (-1 = none).
    task automatic run_frame(input int gs_at, input logic [1:0] gs_new,
                             input int k1, input int k2);
        bit fire;
        for (int c = 0; c < 100; c++) begin
            vsync     = (c < 10);
            key_space = (c == k1) || (c == k2);
            if (c == gs_at) game_state = gs_new;
            fire = key_space && m_prompt_act() && !m_latched;
            if (fire) m_latched = 1'b1;
            @(posedge clk); #1;
            if (c == 1) m_tick(game_state);
            chk("enables", {title_en, prompt_en, over_en, score_en}, m_en());
            chk("start_req", {3'b000, start_req}, {3'b000, fire});
        end
        key_space = 1'b0;
    endtask

    initial begin
        game_state = 2'b00;
        rst = 1'b1; vsync = 1'b0; key_space = 1'b0;
        do_reset(3);

        // hold-off, blink pattern and steady-prompt duration
        repeat (13) run_frame(-1, 2'b00, -1, -1);
        // press in MENU_PROMPT, then a repeat 10 cycles later
        run_frame(-1, 2'b00, 20, 30);
        run_frame(-1, 2'b00, 5, -1);

        // game flow: MENU -> PLAY -> OVER, changes mid-frame
        run_frame(50, 2'b01, -1, -1);
        run_frame(-1, 2'b01, 60, -1);
        run_frame(40, 2'b10, -1, -1);
        repeat (4) run_frame(-1, 2'b10, -1, -1);

        // key on the tick cycle while the state also leaves OVER_PROMPT
        run_frame(0, 2'b00, 1, -1);
        // press during MENU_HOLD is dropped, not queued
        run_frame(-1, 2'b00, 50, -1);
        repeat (5) run_frame(-1, 2'b00, -1, -1);

        // reset while in OVER_PROMPT
        run_frame(30, 2'b10, -1, -1);
        repeat (3) run_frame(-1, 2'b10, -1, -1);
        do_reset(1);
        repeat (3) run_frame(-1, 2'b10, -1, -1);

        // reserved code behaves as PLAY
        run_frame(20, 2'b11, -1, -1);
        run_frame(-1, 2'b11, -1, -1);

        // randomized flow
        for (int f = 0; f < 30; f++) begin
            int gs_at, k1, k2;
            gs_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 99)) : -1;
            k1    = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 99)) : -1;
            k2    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 99)) : -1;
            run_frame(gs_at, 2'($urandom_range(0, 3)), k1, k2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
